// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction-fetch front end.
package fetch_pkg;

    localparam int unsigned DEF_XLEN    = 32;
    localparam int unsigned DEF_ADDR_W  = 32;
    localparam int unsigned DEF_PC_STEP = 4;

    typedef struct packed {
        logic [DEF_XLEN-1:0]   instr;
        logic [DEF_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry circular buffer of fetch entries; flush has priority over push/pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fetch_entry_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  entry_t                     wdata,
    output entry_t                     rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;

    // Explicit wrap so non-power-of-two depths never index past the last entry.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop = pop && (count != '0);
    assign rdata  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (rst)
        !(push && !flush && !do_pop && (count == CNT_W'(DEPTH))));

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: PC, credit-gated imem requests, in-flight slot and
// a prefetch queue feeding IF/ID over valid/ready, with zero-bubble redirect.
module if_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned       XLEN     = DEF_XLEN,
    parameter int unsigned       ADDR_W   = DEF_ADDR_W,
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       PC_STEP  = DEF_PC_STEP,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_en,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic                       imem_req,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [XLEN-1:0]            imem_rdata,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [XLEN-1:0]            id_instr,
    output logic [ADDR_W-1:0]          id_pc,
    output logic [ADDR_W-1:0]          id_next_pc,
    output logic [$clog2(DEPTH+1)-1:0] q_count
);

    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [XLEN-1:0]   instr;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight_v;
    logic              pop;
    logic              push;
    logic              credit_ok;
    logic [CNT_W:0]    occupancy;
    entry_t            head;
    entry_t            wr_entry;

    assign id_valid  = (q_count != '0);
    assign pop       = id_valid && id_ready;
    assign push      = inflight_v && !redirect_valid;
    assign occupancy = {1'b0, q_count} + (CNT_W+1)'(inflight_v) - (CNT_W+1)'(pop);
    assign credit_ok = occupancy < (CNT_W+1)'(DEPTH);

    // A redirect empties both queue and in-flight slot, so its own fetch always has room.
    assign imem_req  = !rst && fetch_en && (redirect_valid || credit_ok);
    assign imem_addr = redirect_valid ? redirect_pc : pc_q;
    assign wr_entry  = '{instr: imem_rdata, pc: inflight_pc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            inflight_v  <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight_v  <= imem_req;
            inflight_pc <= imem_addr;
            if (imem_req) begin
                pc_q <= imem_addr + ADDR_W'(PC_STEP);
            end else if (redirect_valid) begin
                pc_q <= redirect_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (wr_entry),
        .rdata (head),
        .count (q_count)
    );

    assign id_instr   = id_valid ? head.instr : '0;
    assign id_pc      = id_valid ? head.pc : '0;
    assign id_next_pc = id_valid ? head.pc + ADDR_W'(PC_STEP) : '0;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Randomized bench: a program-order model (expected next PC) checks every accepted
// instruction of a DEPTH=4 instance and a wrapping DEPTH=3 instance.
module tb_if_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        a_req, a_valid, a_ready;
    logic [31:0] a_addr, a_rdata, a_instr, a_pc, a_next_pc, a_mem_q;
    logic [2:0]  a_q_count;

    logic        w_req, w_valid, w_ready;
    logic        w_fetch_en = 1'b1;
    logic        w_redirect = 1'b0;
    logic [31:0] w_redirect_pc = '0;
    logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_next_pc, w_mem_q;
    logic [1:0]  w_q_count;

    logic [31:0] a_exp, w_exp, nxt;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned w_pops   = 0;

    always #5 clk = ~clk;

    if_prefetch_queue #(.DEPTH(4)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (a_req),
        .imem_addr      (a_addr),
        .imem_rdata     (a_rdata),
        .id_valid       (a_valid),
        .id_ready       (a_ready),
        .id_instr       (a_instr),
        .id_pc          (a_pc),
        .id_next_pc     (a_next_pc),
        .q_count        (a_q_count)
    );

    if_prefetch_queue #(.DEPTH(3), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (w_fetch_en),
        .redirect_valid (w_redirect),
        .redirect_pc    (w_redirect_pc),
        .imem_req       (w_req),
        .imem_addr      (w_addr),
        .imem_rdata     (w_rdata),
        .id_valid       (w_valid),
        .id_ready       (w_ready),
        .id_instr       (w_instr),
        .id_pc          (w_pc),
        .id_next_pc     (w_next_pc),
        .q_count        (w_q_count)
    );

    // Synchronous-read memory whose word at address A is A >> 2.
    always @(posedge clk) begin
        if (a_req) a_mem_q <= a_addr;
        if (w_req) w_mem_q <= w_addr;
    end
    assign a_rdata = a_mem_q >> 2;
    assign w_rdata = w_mem_q >> 2;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One clock cycle: inputs already driven; model evaluated at the negedge.
    task automatic step();
        w_ready = ($urandom % 2) == 0;
        @(negedge clk);
        if (rst) begin
            a_exp = 32'h0;
            w_exp = 32'hFFFF_FFF8;
        end else begin
            check("a_qcount_le_depth", 64'(a_q_count <= 3'd4), 64'd1);
            check("w_qcount_le_depth", 64'(w_q_count <= 2'd3), 64'd1);
            if (redirect_valid) begin
                a_exp = redirect_pc;
            end else if (a_valid && a_ready) begin
                nxt = a_exp + 32'd4;
                check("a_pop_pc", a_pc, a_exp);
                check("a_pop_instr", a_instr, a_exp >> 2);
                check("a_pop_next_pc", a_next_pc, nxt);
                a_exp = nxt;
            end
            if (w_valid && w_ready) begin
                nxt = w_exp + 32'd4;
                check("w_pop_pc", w_pc, w_exp);
                check("w_pop_instr", w_instr, w_exp >> 2);
                check("w_pop_next_pc", w_next_pc, nxt);
                w_exp = nxt;
                w_pops++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; fetch_en = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        a_ready = 1'b1; w_ready = 1'b0;
        a_exp = '0; w_exp = 32'hFFFF_FFF8;

        @(negedge clk);
        check("rst_id_valid", a_valid, 0);
        check("rst_q_count", a_q_count, 0);
        check("rst_imem_req", a_req, 0);
        check("rst_id_instr", a_instr, 0);
        check("rst_id_pc", a_pc, 0);
        check("rst_id_next_pc", a_next_pc, 0);
        check("rst_w_imem_req", w_req, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // First request right after release, data two cycles later.
        #1;
        check("first_req", a_req, 1);
        check("first_addr", a_addr, 32'h0);
        step();
        check("lat_not_yet", a_valid, 0);
        step();
        check("lat_valid", a_valid, 1);
        check("lat_pc", a_pc, 32'h0);
        step();

        // Redirect while 'h8 is in flight.
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        #1;
        check("redir_req", a_req, 1);
        check("redir_addr", a_addr, 32'h100);
        step();
        redirect_valid = 1'b0;
        step();
        check("redir_t2_valid", a_valid, 1);
        check("redir_t2_pc", a_pc, 32'h100);

        repeat (12) begin
            check("stream_valid", a_valid, 1);
            step();
        end

        // Stall: queue saturates, requests stop, nothing lost.
        a_ready = 1'b0;
        repeat (10) step();
        check("stall_q_full", a_q_count, 4);
        check("stall_no_req", a_req, 0);
        a_ready = 1'b1;
        repeat (8) step();

        // Redirect combined with a pop on a full queue.
        a_ready = 1'b0;
        for (int i = 0; i < 10 && a_q_count != 3'd4; i++) step();
        check("refill_full", a_q_count, 4);
        a_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        check("flush_q_count", a_q_count, 0);
        step();
        check("flush_t2_pc", a_pc, 32'h100);
        repeat (6) step();

        // Reset mid-stream with three entries queued.
        a_ready = 1'b0;
        for (int i = 0; i < 20 && a_q_count != 3'd3; i++) step();
        check("midrst_fill", a_q_count, 3);
        rst = 1'b1;
        #1;
        check("midrst_q_count", a_q_count, 0);
        check("midrst_valid", a_valid, 0);
        check("midrst_req", a_req, 0);
        step();
        rst = 1'b0;
        #1;
        check("midrst_first_req", a_req, 1);
        check("midrst_first_addr", a_addr, 32'h0);

        // Randomized traffic with redirects and fetch gating.
        for (int i = 0; i < 400; i++) begin
            a_ready        = ($urandom % 4) != 0;
            fetch_en       = ($urandom % 8) != 0;
            redirect_valid = ($urandom % 16) == 0;
            redirect_pc    = $urandom & 32'h0000_0FFC;
            step();
        end
        redirect_valid = 1'b0;

        // fetch_en low: in-flight data lands, queue drains to empty.
        fetch_en = 1'b0; a_ready = 1'b1;
        repeat (8) step();
        check("drain_q_count", a_q_count, 0);
        check("drain_valid", a_valid, 0);
        check("drain_no_req", a_req, 0);
        check("wrap_pops", 64'(w_pops >= 8), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
